// File: rtl/ysyx_22041412_mdu_pkg.sv
// Shared encodings for the M-extension multiply/divide controller: func3 codes,
// controller states and the most-negative operand constants.
package ysyx_22041412_mdu_pkg;

   localparam logic [2:0] FUNC3_MUL    = 3'b000;
   localparam logic [2:0] FUNC3_MULH   = 3'b001;
   localparam logic [2:0] FUNC3_MULHSU = 3'b010;
   localparam logic [2:0] FUNC3_MULHU  = 3'b011;
   localparam logic [2:0] FUNC3_DIV    = 3'b100;
   localparam logic [2:0] FUNC3_DIVU   = 3'b101;
   localparam logic [2:0] FUNC3_REM    = 3'b110;
   localparam logic [2:0] FUNC3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [31:0] MIN32 = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041412_mdu_fixup.sv
// Combinational RISC-V div/rem corner-case resolver: divide-by-zero and signed
// overflow produce an architecturally fixed result without using the unit.
module ysyx_22041412_mdu_fixup
   import ysyx_22041412_mdu_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [2:0]      func3_i,
   input  logic            w_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            fast_o,
   output logic [XLEN-1:0] fast_result_o
);

   localparam logic [XLEN-1:0] MIN_X = XLEN'(MIN64 >> (64 - XLEN));

   logic            is_divrem;
   logic            is_rem;
   logic            is_signed;
   logic            div_zero;
   logic            overflow;
   logic [XLEN-1:0] dividend;

   always_comb begin
      is_divrem = 1'b0;
      is_rem    = 1'b0;
      is_signed = 1'b0;
      case (func3_i)
         FUNC3_MUL, FUNC3_MULH, FUNC3_MULHSU, FUNC3_MULHU: is_divrem = 1'b0;
         FUNC3_DIV: begin
            is_divrem = 1'b1;
            is_signed = 1'b1;
         end
         FUNC3_DIVU: is_divrem = 1'b1;
         FUNC3_REM: begin
            is_divrem = 1'b1;
            is_rem    = 1'b1;
            is_signed = 1'b1;
         end
         FUNC3_REMU: begin
            is_divrem = 1'b1;
            is_rem    = 1'b1;
         end
         default: is_divrem = 1'b0;
      endcase

      // *W ops look only at the low word; the dividend comes back sign-extended
      if (w_i) begin
         div_zero = (rs2_i[31:0] == '0);
         overflow = is_signed && (rs1_i[31:0] == MIN32) && (rs2_i[31:0] == '1);
         dividend = {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]};
      end else begin
         div_zero = (rs2_i == '0);
         overflow = is_signed && (rs1_i == MIN_X) && (rs2_i == '1);
         dividend = rs1_i;
      end

      fast_o = is_divrem && (div_zero || overflow);
      if (div_zero) begin
         fast_result_o = is_rem ? dividend : '1;
      end else begin
         fast_result_o = is_rem ? '0 : dividend;
      end
   end

endmodule

// File: rtl/ysyx_22041412_mdu_ctrl.sv
// Initiator side of the en/ready multiply-divide unit handshake: one op in flight,
// local div/rem corner resolution, *W sign extension.
// Optional BUSY watchdog enabled by defining YSYX_22041412_MDU_TIMEOUT_EN.
module ysyx_22041412_mdu_ctrl
   import ysyx_22041412_mdu_pkg::*;
#(
   parameter int unsigned XLEN           = 64,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_func3,
   input  logic            req_w,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic [4:0]      req_rd,
   input  logic            flush,
   output logic            stall,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic [4:0]      resp_rd,
   output logic            resp_err,
   output logic            mdu_en,
   output logic [XLEN-1:0] mdu_rsA,
   output logic [XLEN-1:0] mdu_rsB,
   output logic [2:0]      mdu_func3,
   output logic            mdu_w_en,
   input  logic            mdu_ready,
   input  logic [XLEN-1:0] mdu_result
);

   mdu_state_e      state_q;
   logic [2:0]      func3_q;
   logic            w_q;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] resp_data_q;
   logic            resp_valid_q;
   logic            resp_err_q;

   logic            fast;
   logic [XLEN-1:0] fast_result;
   logic [XLEN-1:0] unit_result;
   logic            timeout;

   ysyx_22041412_mdu_fixup #(
      .XLEN (XLEN)
   ) u_fixup (
      .func3_i       (req_func3),
      .w_i           (req_w),
      .rs1_i         (req_rs1),
      .rs2_i         (req_rs2),
      .fast_o        (fast),
      .fast_result_o (fast_result)
   );

   assign unit_result = w_q ? {{(XLEN-32){mdu_result[31]}}, mdu_result[31:0]} : mdu_result;

`ifdef YSYX_22041412_MDU_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q;

   // Held at zero outside BUSY, so every BUSY entry starts a fresh count
   always_ff @(posedge clk) begin
      if (rst || (state_q != BUSY)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         func3_q      <= '0;
         w_q          <= 1'b0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         if (flush) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (req_valid) begin
                     func3_q <= req_func3;
                     w_q     <= req_w;
                     rs1_q   <= req_rs1;
                     rs2_q   <= req_rs2;
                     rd_q    <= req_rd;
                     if (fast) begin
                        resp_data_q  <= fast_result;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                     end else begin
                        state_q <= BUSY;
                     end
                  end
               end
               BUSY: begin
                  if (mdu_ready) begin
                     resp_data_q  <= unit_result;
                     resp_valid_q <= 1'b1;
                     state_q      <= DONE;
                  end else if (timeout) begin
                     resp_data_q  <= '0;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= DONE;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign stall      = (state_q != IDLE) || (req_valid && !fast);
   assign mdu_en     = (state_q == BUSY);
   // A flush landing in DONE must still swallow the pulse
   assign resp_valid = resp_valid_q && !flush;
   assign resp_err   = resp_err_q && !flush;
   assign resp_data  = resp_data_q;
   assign resp_rd    = rd_q;
   assign mdu_rsA    = rs1_q;
   assign mdu_rsB    = rs2_q;
   assign mdu_func3  = func3_q;
   assign mdu_w_en   = w_q;

endmodule

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
// Self-checking bench for ysyx_22041412_mdu_ctrl: RISC-V M reference model,
// emulated unit with variable latency, per-cycle timeline scoreboard.
module tb_ysyx_22041412_mdu_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_func3;
   logic        req_w;
   logic [63:0] req_rs1;
   logic [63:0] req_rs2;
   logic [4:0]  req_rd;
   logic        flush;
   logic        stall;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;
   logic        mdu_en;
   logic [63:0] mdu_rsA;
   logic [63:0] mdu_rsB;
   logic [2:0]  mdu_func3;
   logic        mdu_w_en;
   logic        mdu_ready;
   logic [63:0] mdu_result;

   ysyx_22041412_mdu_ctrl #(
      .XLEN           (64),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_func3  (req_func3),
      .req_w      (req_w),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_rd     (req_rd),
      .flush      (flush),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_err   (resp_err),
      .mdu_en     (mdu_en),
      .mdu_rsA    (mdu_rsA),
      .mdu_rsB    (mdu_rsB),
      .mdu_func3  (mdu_func3),
      .mdu_w_en   (mdu_w_en),
      .mdu_ready  (mdu_ready),
      .mdu_result (mdu_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // expected per-cycle timeline, keyed by cycle number
   bit          busy_m[int];
   bit          en_m[int];
   bit          v_m[int];
   logic [63:0] data_m[int];
   logic [4:0]  rd_m[int];
   bit          err_m[int];
   logic [63:0] exp_rs1, exp_rs2;
   logic [2:0]  exp_f;
   logic        exp_w;
   bit          req_fast_tb = 1'b0;

   // emulated unit controls
   int          unit_lat = 1;
   logic [63:0] unit_raw = '0;
   bit          stray = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] sext32(input logic [31:0] x);
      return {{32{x[31]}}, x};
   endfunction

   function automatic logic [63:0] sdiv(input logic [63:0] a, input logic [63:0] b, input bit rem);
      logic [63:0] ua, ub;
      if (b == 64'd0) return rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      ua = a[63] ? -a : a;
      ub = b[63] ? -b : b;
      if (rem) return a[63] ? -(ua % ub) : (ua % ub);
      return (a[63] ^ b[63]) ? -(ua / ub) : (ua / ub);
   endfunction

   function automatic logic [63:0] udiv(input logic [63:0] a, input logic [63:0] b, input bit rem);
      if (b == 64'd0) return rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      return rem ? (a % b) : (a / b);
   endfunction

   // architectural RISC-V result
   function automatic logic [63:0] rv_ref(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [63:0]  sa, sb, za, zb, t;
      logic [31:0]  m32;
      if (!w) begin
         case (f)
            3'd0: return a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            3'd4: return sdiv(a, b, 1'b0);
            3'd5: return udiv(a, b, 1'b0);
            3'd6: return sdiv(a, b, 1'b1);
            default: return udiv(a, b, 1'b1);
         endcase
      end
      sa = sext32(a[31:0]); sb = sext32(b[31:0]);
      za = {32'd0, a[31:0]}; zb = {32'd0, b[31:0]};
      case (f)
         3'd0: begin m32 = a[31:0] * b[31:0]; return sext32(m32); end
         3'd4: t = sdiv(sa, sb, 1'b0);
         3'd5: t = udiv(za, zb, 1'b0);
         3'd6: t = sdiv(sa, sb, 1'b1);
         3'd7: t = udiv(za, zb, 1'b1);
         default: t = '0;
      endcase
      return sext32(t[31:0]);
   endfunction

   function automatic bit is_fast(input logic [2:0] f, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] xa, xb;
      if (f < 3'd4) return 1'b0;
      xa = w ? sext32(a[31:0]) : a;
      xb = w ? sext32(b[31:0]) : b;
      if (xb == 64'd0) return 1'b1;
      return (f == 3'd4 || f == 3'd6) && (xb == 64'hFFFF_FFFF_FFFF_FFFF) &&
             (xa == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
   endfunction

   // emulated unit: ready after lat cycles of en, garbage result otherwise
   initial begin
      int en_cnt;
      en_cnt     = 0;
      mdu_ready  = 1'b0;
      mdu_result = '0;
      forever begin
         @(posedge clk); #1;
         mdu_ready  = 1'b0;
         mdu_result = {$urandom, $urandom};
         if (mdu_en) begin
            en_cnt++;
            if (unit_lat != 0 && en_cnt == unit_lat) begin
               mdu_ready  = 1'b1;
               mdu_result = unit_raw;
            end
         end else begin
            en_cnt = 0;
         end
         if (stray) mdu_ready = 1'b1;
      end
   end

   // per-cycle compare against the timeline
   initial begin
      int n;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            n = cyc;
            chk("req_ready", 64'(req_ready), 64'(!busy_m.exists(n)));
            chk("mdu_en", 64'(mdu_en), 64'(en_m.exists(n)));
            chk("resp_valid", 64'(resp_valid), 64'(v_m.exists(n)));
            chk("stall", 64'(stall), 64'(busy_m.exists(n) || (req_valid && !req_fast_tb)));
            if (v_m.exists(n)) begin
               chk("resp_data", resp_data, data_m[n]);
               chk("resp_rd", 64'(resp_rd), 64'(rd_m[n]));
               chk("resp_err", 64'(resp_err), 64'(err_m[n]));
            end
            if (en_m.exists(n)) begin
               chk("mdu_rsA", mdu_rsA, exp_rs1);
               chk("mdu_rsB", mdu_rsB, exp_rs2);
               chk("mdu_func3", 64'(mdu_func3), 64'(exp_f));
               chk("mdu_w_en", 64'(mdu_w_en), 64'(exp_w));
            end
         end
      end
   end

   // lat=0 means the unit never answers; kill_at=j kills in j-th cycle after accept
   task automatic do_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int lat,
                        input int kill_at, input bit kill_rst, input bit has_lit,
                        input logic [63:0] lit, input logic [31:0] upper, input string nm);
      bit          fst;
      logic [63:0] mref, expd;
      int          A, kc, ncyc, last;
      bit          tmo;
      fst  = is_fast(f, w, a, b);
      mref = rv_ref(f, w, a, b);
      expd = mref;
      if (has_lit) begin
         chk({"model_", nm}, mref, lit);
         expd = lit;
      end
      unit_raw = w ? {upper, mref[31:0]} : mref;
      unit_lat = lat;
      tmo      = !fst && (lat == 0);
      ncyc     = fst ? 0 : (tmo ? TO : lat);
      req_valid = 1'b1; req_func3 = f; req_w = w; req_rs1 = a; req_rs2 = b; req_rd = rd;
      req_fast_tb = fst;
      exp_rs1 = a; exp_rs2 = b; exp_f = f; exp_w = w;
      A    = cyc + 1;
      kc   = (kill_at > 0) ? A + kill_at - 1 : 32'h3FFF_FFFF;
      last = A + ncyc;
      for (int i = 0; i <= ncyc; i++) begin
         if (A + i <= kc) begin
            busy_m[A + i] = 1'b1;
            if (i < ncyc) en_m[A + i] = 1'b1;
         end
      end
      if (A + ncyc < kc) begin
         v_m[A + ncyc]    = 1'b1;
         data_m[A + ncyc] = tmo ? 64'd0 : expd;
         rd_m[A + ncyc]   = rd;
         err_m[A + ncyc]  = tmo;
      end
      if (kc < last) last = kc;
      @(posedge clk); #1;
      req_valid = 1'b0; req_fast_tb = 1'b0;
      req_func3 = 3'($urandom); req_w = 1'($urandom);
      req_rs1 = {$urandom, $urandom}; req_rs2 = {$urandom, $urandom}; req_rd = 5'($urandom);
      while (cyc <= last) begin
         flush = !kill_rst && (cyc == kc);
         rst   = kill_rst && (cyc == kc);
         @(posedge clk); #1;
      end
      flush = 1'b0;
      rst   = 1'b0;
   endtask

   function automatic logic [63:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h8000_0000_0000_0000;
         3: return {$urandom, 32'h8000_0000};
         4: return {$urandom, 32'hFFFF_FFFF};
         5: return {$urandom, 32'h0000_0000};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] f;
      logic       w;
      rst = 1'b1; req_valid = 1'b0; req_func3 = '0; req_w = 1'b0;
      req_rs1 = '0; req_rs2 = '0; req_rd = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_mdu_en", 64'(mdu_en), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_resp_rd", 64'(resp_rd), 64'd0);
      chk("rst_mdu_rsA", mdu_rsA, 64'd0);
      chk("rst_mdu_rsB", mdu_rsB, 64'd0);
      chk("rst_mdu_func3", 64'(mdu_func3), 64'd0);
      chk("rst_mdu_w_en", 64'(mdu_w_en), 64'd0);
      @(posedge clk); #1;
      chk_en = 1'b1;

      do_op(3'd5, 1'b0, 64'd100, 64'd7, 5'd3, 2, 0, 0, 1, 64'd14, 32'd0, "divu");
      do_op(3'd4, 1'b0, 64'h1234, 64'd0, 5'd4, 2, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, "div0");
      do_op(3'd6, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 5'd5, 2, 0, 0, 1,
            64'h0123_4567_89AB_CDEF, 32'd0, "rem0");
      do_op(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd6, 2, 0, 0, 1,
            64'hFFFF_FFFF_8000_0000, 32'd0, "divw_ovf");
      do_op(3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd7, 2, 0, 0, 1, 64'd0, 32'd0, "remw_ovf");
      do_op(3'd0, 1'b1, 64'h4000_0000, 64'd2, 5'd17, 2, 0, 0, 1,
            64'hFFFF_FFFF_8000_0000, 32'd0, "mulw");
      do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 2, 0, 0, 1,
            64'h8000_0000_0000_0000, 32'd0, "div_ovf");
      do_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 2, 0, 0, 1,
            64'd0, 32'd0, "rem_ovf");

      // flush in first BUSY cycle, then a stray unit ready while idle
      do_op(3'd5, 1'b0, 64'd100, 64'd7, 5'd10, 3, 1, 0, 0, '0, 32'd0, "flush_busy");
      stray = 1'b1;
      @(posedge clk); #1;
      stray = 1'b0;
      // flush while DONE on the fast path
      do_op(3'd5, 1'b0, 64'd55, 64'd0, 5'd11, 1, 1, 0, 0, '0, 32'd0, "flush_done");
      // flush in IDLE with a request offered: no accept
      req_valid = 1'b1; req_func3 = 3'd5; req_w = 1'b0; req_rs1 = 64'd9; req_rs2 = 64'd3;
      req_fast_tb = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      // reset in the middle of a long unit op
      do_op(3'd1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd12, 4, 2, 1, 0, '0,
            32'd0, "rst_mid");
      @(negedge clk);
      chk("midrst_mdu_rsA", mdu_rsA, 64'd0);
      chk("midrst_resp_data", resp_data, 64'd0);
      chk("midrst_resp_rd", 64'(resp_rd), 64'd0);
      @(posedge clk); #1;

`ifdef YSYX_22041412_MDU_TIMEOUT_EN
      do_op(3'd5, 1'b0, 64'd100, 64'd7, 5'd13, 0, 0, 0, 0, '0, 32'd0, "timeout");
`endif

      for (int i = 0; i < 250; i++) begin
         w = 1'($urandom);
         f = 3'($urandom);
         if (w && f != 3'd0 && f < 3'd4) f = 3'd0;
         do_op(f, w, rnd_opnd(), rnd_opnd(), 5'($urandom), $urandom_range(1, 4),
               ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0, 0, 0, '0, $urandom, "rnd");
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) begin
         @(posedge clk); #1;
      end
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
